ram_ctrl: RTL and testbench

Request-driven initiator for the single-port synchronous `ram` block: it owns the RAM's `en/we/addr/din` inputs and consumes its `dout`. Upstream logic (CPU load/store path, DMA-style fill) issues requests over a valid/ready channel. A request is either a fill, which writes one value to `len+1` consecutive addresses, or a burst read, which returns `len+1` consecutive words over a backpressured response channel. Addresses wrap modulo 2^AW.

---
 rtl/ram_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ram_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// ram_ctrl: request-driven initiator for a single-port synchronous RAM.
// A request is either a fill, which writes one value to len+1 consecutive
// addresses, or a burst read, which returns len+1 consecutive words over a
// backpressured response channel. Addresses wrap modulo 2^AW.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid=1 and ready=1. Once raised, valid and its payload stay stable
// until that edge. Ready may be high while valid is low, and then has no effect.
//
// Every output is a flop. Next-cycle values are derived from the next state,
// so a state's outputs appear in the same cycle as the state itself.
module ram_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [AW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_last,
  output logic          wr_done,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    RD_RESP  = 3'd4
  } state_t;

  state_t        state, state_d;

  // Current address and remaining beat count. The address register drives
  // ram_addr directly, and the latched fill value drives ram_din.
  logic [AW-1:0] a, a_d;
  logic [AW-1:0] n, n_d;
  logic [DW-1:0] wdata, wdata_d;

  logic          req_ready_d;
  logic          rsp_valid_d;
  logic [DW-1:0] rsp_data_d;
  logic          rsp_last_d;
  logic          wr_done_d;
  logic          ram_en_d;
  logic          ram_we_d;

  logic          accept;
  logic          consume;

  assign accept    = req_valid && req_ready;
  assign consume   = rsp_valid && rsp_ready;
  assign ram_addr  = a;
  assign ram_din   = wdata;
  assign dbg_state = state;

  // State register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, datapath updates and next-cycle output values.
  always_comb begin
    state_d     = state;
    a_d         = a;
    n_d         = n;
    wdata_d     = wdata;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    rsp_last_d  = rsp_last;
    wr_done_d   = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          a_d     = req_addr;
          n_d     = req_len;
          wdata_d = req_wdata;
          state_d = req_we ? FILL : RD_ISSUE;
        end
      end
      FILL: begin
        // One write per cycle. The beat with n==0 is the last one.
        if (n == '0) begin
          state_d   = IDLE;
          wr_done_d = 1'b1;
        end else begin
          a_d = a + 1'b1;
          n_d = n - 1'b1;
        end
      end
      RD_ISSUE: begin
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        // ram_dout holds the word addressed during RD_ISSUE.
        rsp_data_d  = ram_dout;
        rsp_valid_d = 1'b1;
        rsp_last_d  = (n == '0);
        state_d     = RD_RESP;
      end
      RD_RESP: begin
        // Hold the beat until the consumer takes it. No RAM access meanwhile.
        if (consume) begin
          rsp_valid_d = 1'b0;
          rsp_last_d  = 1'b0;
          if (n == '0) begin
            state_d = IDLE;
          end else begin
            a_d     = a + 1'b1;
            n_d     = n - 1'b1;
            state_d = RD_ISSUE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    ram_en_d    = (state_d == FILL) || (state_d == RD_ISSUE);
    ram_we_d    = (state_d == FILL);
  end

  // Datapath and output registers. Reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      a         <= '0;
      n         <= '0;
      wdata     <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      wr_done   <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
    end else begin
      a         <= a_d;
      n         <= n_d;
      wdata     <= wdata_d;
      req_ready <= req_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
      rsp_last  <= rsp_last_d;
      wr_done   <= wr_done_d;
      ram_en    <= ram_en_d;
      ram_we    <= ram_we_d;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: drives ram_ctrl against a behavioural single-port RAM. An
// expected-memory array tracks what every completed fill should have left
// in the RAM, and each burst read is checked against words taken from it.
`timescale 1ps/1ps
module tb_ram_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  // Clock and reset.
  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [AW-1:0] req_len;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_last;
  logic          wr_done;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout = '0;
  logic [2:0]    dbg_state;

  ram_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .areset    (areset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .wr_done   (wr_done),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .dbg_state (dbg_state)
  );

  // Behavioural single-port synchronous RAM with an access counter.
  logic [DW-1:0] ram_mem [16];
  int            ram_acc = 0;
  always @(posedge clk) begin
    if (ram_en) begin
      ram_acc <= ram_acc + 1;
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  // Reference model and scoreboard state.
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] exp_q [$];
  int            chk_cnt  = 0;
  int            pass_cnt = 0;

  // Watchdog: the run must finish by itself.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Waits (bounded) for req_ready, presents one request, and returns in
  // cycle 1 after the accept edge with the request inputs scrambled.
  task automatic accept(input logic we, input logic [AW-1:0] addr,
                        input logic [AW-1:0] len, input logic [DW-1:0] wd);
    int t;
    t = 0;
    while (req_ready !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL accept_wait: req_ready=%b want 1", req_ready);
    else pass_cnt++;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_len   = len;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 4'($urandom);
    req_len   = 4'($urandom);
    req_wdata = 8'($urandom);
  endtask

  // Fill: one write per cycle from cycle 1, wr_done and req_ready in cycle len+2.
  task automatic run_fill(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                          input logic [DW-1:0] wd);
    accept(1'b1, addr, len, wd);
    for (int k = 0; k <= int'(len); k++) begin
      chk_cnt++;
      if ({ram_en, ram_we, ram_addr, ram_din, req_ready, wr_done, rsp_valid} !==
          {2'b11, 4'(int'(addr) + k), wd, 3'b000})
        $display("FAIL fill_beat%0d: en/we/addr/din/rdy/done/rv=%b/%b/%0d/%h/%b/%b/%b want 1/1/%0d/%h/0/0/0",
                 k, ram_en, ram_we, ram_addr, ram_din, req_ready, wr_done, rsp_valid,
                 4'(int'(addr) + k), wd);
      else pass_cnt++;
      model_mem[4'(int'(addr) + k)] = wd;
      step();
    end
    chk_cnt++;
    if ({wr_done, req_ready, ram_en, rsp_valid} !== 4'b1100)
      $display("FAIL fill_done: done/rdy/en/rv=%b%b%b%b want 1100", wr_done, req_ready, ram_en, rsp_valid);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({wr_done, req_ready} !== 2'b01)
      $display("FAIL fill_pulse: done/rdy=%b%b want 01", wr_done, req_ready);
    else pass_cnt++;
  endtask

  // Burst read: beat 0 stalls stall0 cycles, later beats up to max_stall.
  task automatic run_read(input logic [AW-1:0] addr, input logic [AW-1:0] len,
                          input int stall0, input int max_stall);
    int            st;
    logic [DW-1:0] exp_w;
    rsp_ready = 1'b0;
    exp_q.delete();
    for (int b = 0; b <= int'(len); b++) exp_q.push_back(model_mem[4'(int'(addr) + b)]);
    accept(1'b0, addr, len, 8'($urandom));
    for (int b = 0; b <= int'(len); b++) begin
      st = (b == 0) ? stall0 : int'($urandom_range(0, max_stall));
      exp_w = exp_q.pop_front();
      rsp_ready = (st == 0);
      chk_cnt++;
      if ({ram_en, ram_we, ram_addr, rsp_valid, req_ready, wr_done} !==
          {2'b10, 4'(int'(addr) + b), 3'b000})
        $display("FAIL rd_issue%0d: en/we/addr/rv/rdy/done=%b/%b/%0d/%b/%b/%b want 1/0/%0d/0/0/0",
                 b, ram_en, ram_we, ram_addr, rsp_valid, req_ready, wr_done, 4'(int'(addr) + b));
      else pass_cnt++;
      step();
      chk_cnt++;
      if ({ram_en, rsp_valid, wr_done} !== 3'b000)
        $display("FAIL rd_capt%0d: en/rv/done=%b%b%b want 000", b, ram_en, rsp_valid, wr_done);
      else pass_cnt++;
      step();
      chk_cnt++;
      if ({rsp_valid, rsp_data, rsp_last, ram_en} !== {1'b1, exp_w, (b == int'(len)), 1'b0})
        $display("FAIL rd_beat%0d: rv/data/last/en=%b/%h/%b/%b want 1/%h/%b/0",
                 b, rsp_valid, rsp_data, rsp_last, ram_en, exp_w, (b == int'(len)));
      else pass_cnt++;
      for (int s = 0; s < st; s++) begin
        step();
        chk_cnt++;
        if ({rsp_valid, rsp_data, rsp_last, ram_en} !== {1'b1, exp_w, (b == int'(len)), 1'b0})
          $display("FAIL rd_stall%0d: rv/data/last/en=%b/%h/%b/%b want 1/%h/%b/0",
                   b, rsp_valid, rsp_data, rsp_last, ram_en, exp_w, (b == int'(len)));
        else pass_cnt++;
      end
      rsp_ready = 1'b1;
      step();
    end
    chk_cnt++;
    if ({req_ready, rsp_valid, ram_en, wr_done} !== 4'b1000)
      $display("FAIL rd_done: rdy/rv/en/done=%b%b%b%b want 1000", req_ready, rsp_valid, ram_en, wr_done);
    else pass_cnt++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int acc0;
    areset    = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 4'd5;
    req_len   = 4'd0;
    req_wdata = 8'hFF;
    rsp_ready = 1'b1;
    acc0      = ram_acc;
    #12;
    chk_cnt++;
    if ({req_ready, rsp_valid, rsp_last, wr_done, ram_en, ram_we, ram_addr, ram_din, rsp_data} !== 26'd0)
      $display("FAIL reset_outputs: rdy/rv/last/done/en/we/addr/din/data=%b/%b/%b/%b/%b/%b/%h/%h/%h want all 0",
               req_ready, rsp_valid, rsp_last, wr_done, ram_en, ram_we, ram_addr, ram_din, rsp_data);
    else pass_cnt++;
    chk_cnt++;
    if (ram_acc !== acc0) $display("FAIL reset_no_access: accesses=%0d want %0d", ram_acc, acc0);
    else pass_cnt++;
    areset    = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    step();
    chk_cnt++;
    if ({req_ready, rsp_valid, wr_done, ram_en} !== 4'b1000)
      $display("FAIL reset_release: rdy/rv/done/en=%b%b%b%b want 1000", req_ready, rsp_valid, wr_done, ram_en);
    else pass_cnt++;
  endtask

  task automatic test_single_fill();
    int acc0;
    acc0 = ram_acc;
    run_fill(4'd5, 4'd0, 8'hA4);
    chk_cnt++;
    if (ram_acc - acc0 !== 1) $display("FAIL single_fill_count: accesses=%0d want 1", ram_acc - acc0);
    else pass_cnt++;
    chk_cnt++;
    if (ram_mem[5] !== 8'hA4) $display("FAIL single_fill_mem: mem[5]=%h want a4", ram_mem[5]);
    else pass_cnt++;
  endtask

  task automatic test_wrap_fill();
    run_fill(4'd14, 4'd3, 8'h5A);
    run_read(4'd0, 4'd0, 0, 0);
  endtask

  task automatic test_burst_read();
    for (int i = 0; i < 16; i++) run_fill(4'(i), 4'd0, 8'(i * 8'h11));
    run_read(4'd1, 4'd2, 0, 0);
  endtask

  task automatic test_backpressure();
    run_read(4'd1, 4'd2, 4, 0);
  endtask

  // A second request held while a fill runs is taken only once idle,
  // and reads back the value just written.
  task automatic test_back_to_back();
    accept(1'b1, 4'd3, 4'd2, 8'h77);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 4'd4;
    req_len   = 4'd0;
    req_wdata = 8'h00;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk_cnt++;
      if ({ram_en, ram_we, ram_addr, ram_din, req_ready} !== {2'b11, 4'(3 + k), 8'h77, 1'b0})
        $display("FAIL busy_fill%0d: en/we/addr/din/rdy=%b/%b/%0d/%h/%b want 1/1/%0d/77/0",
                 k, ram_en, ram_we, ram_addr, ram_din, req_ready, 3 + k);
      else pass_cnt++;
      model_mem[4'(3 + k)] = 8'h77;
      step();
    end
    chk_cnt++;
    if ({wr_done, req_ready} !== 2'b11) $display("FAIL busy_done: done/rdy=%b%b want 11", wr_done, req_ready);
    else pass_cnt++;
    step();
    req_valid = 1'b0;
    chk_cnt++;
    if ({ram_en, ram_we, ram_addr, req_ready, wr_done} !== {2'b10, 4'd4, 2'b00})
      $display("FAIL busy_read_issue: en/we/addr/rdy/done=%b/%b/%0d/%b/%b want 1/0/4/0/0",
               ram_en, ram_we, ram_addr, req_ready, wr_done);
    else pass_cnt++;
    step();
    step();
    chk_cnt++;
    if ({rsp_valid, rsp_data, rsp_last} !== {1'b1, model_mem[4], 1'b1})
      $display("FAIL busy_read_beat: rv/data/last=%b/%h/%b want 1/%h/1", rsp_valid, rsp_data, rsp_last, model_mem[4]);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL busy_read_end: rv/rdy=%b%b want 01", rsp_valid, req_ready);
    else pass_cnt++;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int seen;
    int t;
    int acc0;
    rsp_ready = 1'b0;
    accept(1'b0, 4'd0, 4'd7, 8'h00);
    rsp_ready = 1'b1;
    seen = 0;
    t    = 0;
    while (seen < 2 && t < 40) begin
      if (rsp_valid === 1'b1) begin
        chk_cnt++;
        if (rsp_data !== model_mem[seen])
          $display("FAIL mid_beat%0d: data=%h want %h", seen, rsp_data, model_mem[seen]);
        else pass_cnt++;
        seen++;
      end
      step();
      t++;
    end
    chk_cnt++;
    if (seen != 2) $display("FAIL mid_beats_seen: beats=%0d want 2", seen);
    else pass_cnt++;
    #2;
    areset = 1'b0;
    acc0   = ram_acc;
    #1;
    chk_cnt++;
    if ({req_ready, rsp_valid, rsp_last, wr_done, ram_en, ram_we, ram_addr, ram_din, rsp_data} !== 26'd0)
      $display("FAIL mid_reset_outputs: rdy/rv/last/done/en/we/addr/din/data=%b/%b/%b/%b/%b/%b/%h/%h/%h want all 0",
               req_ready, rsp_valid, rsp_last, wr_done, ram_en, ram_we, ram_addr, ram_din, rsp_data);
    else pass_cnt++;
    step();
    areset = 1'b1;
    chk_cnt++;
    if (ram_acc !== acc0) $display("FAIL mid_reset_access: accesses=%0d want %0d", ram_acc, acc0);
    else pass_cnt++;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_cnt++;
      if ({req_ready, rsp_valid, wr_done, ram_en} !== 4'b1000)
        $display("FAIL mid_after_release%0d: rdy/rv/done/en=%b%b%b%b want 1000", c, req_ready, rsp_valid, wr_done, ram_en);
      else pass_cnt++;
    end
    rsp_ready = 1'b0;
    run_read(4'd9, 4'd0, 0, 0);
  endtask

  task automatic test_random();
    logic [AW-1:0] addr;
    logic [AW-1:0] len;
    for (int i = 0; i < 40; i++) begin
      addr = 4'($urandom);
      len  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) run_fill(addr, len, 8'($urandom));
      else                            run_read(addr, len, int'($urandom_range(0, 3)), 2);
      repeat ($urandom_range(0, 2)) step();
    end
    for (int i = 0; i < 16; i++) begin
      chk_cnt++;
      if (ram_mem[i] !== model_mem[i]) $display("FAIL final_mem%0d: ram=%h want %h", i, ram_mem[i], model_mem[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_fill();
    test_wrap_fill();
    test_burst_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
